// File: rtl/if_id_pipe_reg_if.sv
// IF->ID handshake bundle: fetch-side valid/ready/data and decode-side valid/ready/data.
// master = fetch/decode environment, slave = the pipeline register.
interface if_id_pipe_reg_if #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [INST_WIDTH-1:0] inst_i;
    logic [PC_WIDTH-1:0]   pc_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [INST_WIDTH-1:0] inst_o;
    logic [PC_WIDTH-1:0]   pc_o;

    modport master (
        output in_valid_i, inst_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, pc_o
    );

    modport slave (
        input  in_valid_i, inst_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, pc_o
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer and flush.
// Decode sees only the main register; the skid entry absorbs one beat of back-pressure so
// in_ready_o is a pure register (no combinational path from out_ready_i to fetch).
// Optional macro IF_ID_PERF_EN adds stall_cnt_o / flush_cnt_o performance counters.
module if_id_pipe_reg #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    if_id_pipe_reg_if.slave  bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(RESET_INST);

    // Bit 1 = main valid, bit 0 = skid valid; (0,1) is never produced.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [INST_WIDTH-1:0] main_inst_q, main_inst_d;
    logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
    logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic                  main_vld, skid_vld;
    logic                  accept, fire;

    assign main_vld = state_q[1];
    assign skid_vld = state_q[0];

    assign bus.out_valid_o = main_vld;
    assign bus.in_ready_o  = ~skid_vld;
    assign bus.inst_o      = main_inst_q;
    assign bus.pc_o        = main_pc_q;

    // State and data registers; reset returns to EMPTY with NOP / zero PC visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_inst_q <= NOP_INST;
            main_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_pc_q   <= main_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    // Next-state and data steering; flush overrides everything and empties both entries.
    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_pc_d   = main_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        accept      = bus.in_valid_i & ~skid_vld & ~flush_i;
        fire        = main_vld & bus.out_ready_i;

        if (flush_i) begin
            state_d     = EMPTY;
            main_inst_d = NOP_INST;
            main_pc_d   = '0;
            skid_inst_d = NOP_INST;
            skid_pc_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_inst_d = bus.inst_i;
                        main_pc_d   = bus.pc_i;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_inst_d = bus.inst_i;
                        main_pc_d   = bus.pc_i;
                    end else if (accept) begin
                        state_d     = FULL;
                        skid_inst_d = bus.inst_i;
                        skid_pc_d   = bus.pc_i;
                    end else if (fire) begin
                        state_d     = EMPTY;
                        main_inst_d = NOP_INST;
                        main_pc_d   = '0;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_d     = ONE;
                        main_inst_d = skid_inst_q;
                        main_pc_d   = skid_pc_q;
                        skid_inst_d = NOP_INST;
                        skid_pc_d   = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    // Counts decode stalls and flushes that actually discard held entries; both wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (main_vld && !bus.out_ready_i && !flush_i) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush_i && (main_vld || skid_vld)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: reset, streaming, back-pressure, flush, reset mid-op,
// reset+flush together and (with IF_ID_PERF_EN) the performance counters.
module tb_if_id_pipe_reg;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_err;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_id_pipe_reg_if #(.INST_WIDTH(32), .PC_WIDTH(32)) bus ();

    if_id_pipe_reg #(
        .INST_WIDTH(32),
        .PC_WIDTH  (32),
        .RESET_INST(32'h0000_0013)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush),
        .bus    (bus)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Verify the idle/reset output picture.
    task automatic check_idle(input string tag);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL %s out_valid got %b exp 0", tag, bus.out_valid_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL %s in_ready got %b exp 1", tag, bus.in_ready_o); end
        n_cmp++; if (bus.inst_o !== 32'h0000_0013) begin n_err++; $display("FAIL %s inst_o got %h exp 00000013", tag, bus.inst_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL %s pc_o got %h exp 00000000", tag, bus.pc_o); end
    endtask

    // Push one beat presented for a single cycle (fetch then drops valid).
    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid_i = 1'b1;
        bus.inst_i     = inst;
        bus.pc_i       = pc;
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.in_ready_o); end
            bus.in_valid_i = 1'b1;
            bus.inst_i     = 32'hA0 + 32'(i);
            bus.pc_i       = 32'h100 + 32'(4 * i);
            step();
            n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.out_valid_o); end
            n_cmp++; if (bus.inst_o !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL stream_inst[%0d] got %h exp %h", i, bus.inst_o, 32'hA0 + 32'(i)); end
            n_cmp++; if (bus.pc_o !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.pc_o, 32'h100 + 32'(4 * i)); end
        end
        bus.in_valid_i = 1'b0;
        step();
        check_idle("stream_drain");
    endtask

    // Fill to FULL with out_ready low; leaves the third beat held by fetch.
    task automatic fill_full(input logic [31:0] base);
        bus.out_ready_i = 1'b0;
        push(base, 32'h200);
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready_one got %b exp 1", bus.in_ready_o); end
        push(base + 32'd1, 32'h204);
        n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_ready_full got %b exp 0", bus.in_ready_o); end
        n_cmp++; if (bus.inst_o !== base) begin n_err++; $display("FAIL fill_inst_hold got %h exp %h", bus.inst_o, base); end
    endtask

    task automatic test_back_pressure();
        fill_full(32'hB0);
        bus.in_valid_i = 1'b1;
        bus.inst_i     = 32'hB2;
        bus.pc_i       = 32'h208;
        step();
        n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_held got %b exp 0", bus.in_ready_o); end
        n_cmp++; if (bus.inst_o !== 32'hB0 || bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_stable got %h/%b exp b0/1", bus.inst_o, bus.out_valid_o); end
        bus.out_ready_i = 1'b1;
        step();
        n_cmp++; if (bus.inst_o !== 32'hB1 || bus.pc_o !== 32'h204) begin n_err++; $display("FAIL bp_second got %h@%h exp b1@204", bus.inst_o, bus.pc_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_release got %b exp 1", bus.in_ready_o); end
        step();
        bus.in_valid_i = 1'b0;
        n_cmp++; if (bus.inst_o !== 32'hB2 || bus.pc_o !== 32'h208 || bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_third got %h@%h v%b exp b2@208 v1", bus.inst_o, bus.pc_o, bus.out_valid_o); end
        step();
        check_idle("bp_drain");
    endtask

    task automatic test_flush_full();
        fill_full(32'hB8);
        flush          = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.inst_i     = 32'hC0;
        bus.pc_i       = 32'h300;
        step();
        flush          = 1'b0;
        bus.in_valid_i = 1'b0;
        check_idle("flush_full");
        bus.out_ready_i = 1'b0;
        push(32'hC1, 32'h304);
        n_cmp++; if (bus.inst_o !== 32'hC1 || bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL flush_next got %h v%b exp c1 v1", bus.inst_o, bus.out_valid_o); end
        bus.out_ready_i = 1'b1;
        step();
        check_idle("flush_alone");
    endtask

    task automatic test_reset_mid();
        fill_full(32'hD0);
        bus.in_valid_i = 1'b1;
        bus.inst_i     = 32'hD2;
        bus.pc_i       = 32'h208;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("reset_mid");
        bus.out_ready_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        n_cmp++; if (bus.inst_o !== 32'hD2 || bus.pc_o !== 32'h208) begin n_err++; $display("FAIL reset_mid_next got %h@%h exp d2@208", bus.inst_o, bus.pc_o); end
        step();
        check_idle("reset_mid_drain");
    endtask

    task automatic test_reset_and_flush();
        fill_full(32'hE0);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        check_idle("rst_flush");
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_err++; $display("FAIL perf_reset got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        bus.out_ready_i = 1'b0;
        push(32'hF0, 32'h400);
        for (int i = 0; i < 5; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL perf_stall got %0d exp 5", stall_cnt); end
        n_cmp++; if (flush_cnt !== 32'd1) begin n_err++; $display("FAIL perf_flush got %0d exp 1", flush_cnt); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd5) begin n_err++; $display("FAIL perf_flush_empty got %0d/%0d exp 1/5", flush_cnt, stall_cnt); end
    endtask
`endif

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst            = 1'b0;
        flush          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.inst_i     = '0;
        bus.pc_i       = '0;
        bus.out_ready_i = 1'b0;
        #2;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_reset_mid();
        test_reset_and_flush();
`ifdef IF_ID_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
